// File: rtl/id_fwd_pipe_pkg.sv
// Shared decode encodings for the ID stage: RV32I opcodes, instruction index and type codes.
// The NOP codes are what bubbles and illegal instructions carry downstream.
package id_fwd_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int INST_IDX_W  = 5;
  localparam int INST_TYPE_W = 2;

  typedef enum logic [INST_IDX_W-1:0] {
    INST_NOP   = 5'd0,
    INST_LUI   = 5'd1,
    INST_AUIPC = 5'd2,
    INST_ADDI  = 5'd3,
    INST_SLTI  = 5'd4,
    INST_SLTIU = 5'd5,
    INST_XORI  = 5'd6,
    INST_ORI   = 5'd7,
    INST_ANDI  = 5'd8,
    INST_SLLI  = 5'd9,
    INST_SRLI  = 5'd10,
    INST_SRAI  = 5'd11,
    INST_ADD   = 5'd12,
    INST_SUB   = 5'd13,
    INST_SLL   = 5'd14,
    INST_SLT   = 5'd15,
    INST_SLTU  = 5'd16,
    INST_XOR   = 5'd17,
    INST_SRL   = 5'd18,
    INST_SRA   = 5'd19,
    INST_OR    = 5'd20,
    INST_AND   = 5'd21
  } inst_idx_e;

  typedef enum logic [INST_TYPE_W-1:0] {
    TYPE_NOP = 2'd0,
    TYPE_R   = 2'd1,
    TYPE_I   = 2'd2,
    TYPE_U   = 2'd3
  } inst_type_e;

  localparam inst_idx_e  INST_IDX_NOP  = INST_NOP;
  localparam inst_type_e INST_TYPE_NOP = TYPE_NOP;

endpackage

// File: rtl/id_operand_sel.sv
// Resolves one source operand: x0 or an unread operand gives zero, otherwise the
// lowest-index enabled forwarding source that matches wins over the regfile value.
module id_operand_sel #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    used,
  input  logic [4:0]              idx,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_e,
  input  logic [5*NUM_FWD-1:0]    fwd_idx,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic [XLEN-1:0]         data
);

  logic [NUM_FWD-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      assign hit[gi] = fwd_e[gi] && (fwd_idx[5*gi +: 5] == idx);
    end
  endgenerate

  // Walk from oldest to youngest so the youngest matching source overwrites last.
  always_comb begin
    data = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        data = fwd_data[XLEN*i +: XLEN];
      end
    end
    if (!used || idx == 5'd0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/id_fwd_pipe.sv
// Instruction decode stage with operand forwarding, load-use stall and a single
// registered output slot using a valid/ready handshake.
module id_fwd_pipe
  import id_fwd_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    inValid_in,
  output logic                    inReady_out,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [31:0]             inst_in,
  output logic [4:0]              reg1Idx_out,
  output logic [4:0]              reg2Idx_out,
  input  logic [XLEN-1:0]         reg1Data_in,
  input  logic [XLEN-1:0]         reg2Data_in,
  input  logic [NUM_FWD-1:0]      fwdE_in,
  input  logic [5*NUM_FWD-1:0]    fwdIdx_in,
  input  logic [XLEN*NUM_FWD-1:0] fwdData_in,
  input  logic                    ldE_in,
  input  logic [4:0]              ldIdx_in,
  input  logic                    flush_in,
  output logic                    outValid_out,
  input  logic                    outReady_in,
  output logic [XLEN-1:0]         pc_out,
  output logic [INST_IDX_W-1:0]   instIdx_out,
  output logic [INST_TYPE_W-1:0]  instType_out,
  output logic                    rdE_out,
  output logic [4:0]              rdIdx_out,
  output logic [XLEN-1:0]         rs1Data_out,
  output logic [XLEN-1:0]         rs2Data_out,
  output logic [XLEN-1:0]         imm_out,
  output logic                    useImm_out,
  output logic                    illegal_out
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign funct3 = inst_in[14:12];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign funct7 = inst_in[31:25];

  assign reg1Idx_out = rs1;
  assign reg2Idx_out = rs2;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_sh;
  logic [XLEN-1:0] imm_u;

  assign imm_i  = XLEN'($signed(inst_in[31:20]));
  assign imm_sh = XLEN'(inst_in[24:20]);
  assign imm_u  = XLEN'($signed({inst_in[31:12], 12'b0}));

  inst_idx_e       dec_idx;
  inst_type_e      dec_type;
  logic            dec_legal;
  logic            dec_wr;
  logic            dec_use_rs1;
  logic            dec_use_rs2;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_idx     = INST_IDX_NOP;
    dec_type    = INST_TYPE_NOP;
    dec_legal   = 1'b0;
    dec_wr      = 1'b0;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_idx     = (opcode == OPC_LUI) ? INST_LUI : INST_AUIPC;
        dec_type    = TYPE_U;
        dec_legal   = 1'b1;
        dec_wr      = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_u;
      end
      OPC_OP_IMM: begin
        dec_type    = TYPE_I;
        dec_legal   = 1'b1;
        dec_wr      = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
        unique case (funct3)
          3'b000: dec_idx = INST_ADDI;
          3'b010: dec_idx = INST_SLTI;
          3'b011: dec_idx = INST_SLTIU;
          3'b100: dec_idx = INST_XORI;
          3'b110: dec_idx = INST_ORI;
          3'b111: dec_idx = INST_ANDI;
          3'b001: begin
            dec_idx   = INST_SLLI;
            dec_imm   = imm_sh;
            dec_legal = (funct7 == F7_BASE);
          end
          default: begin
            dec_idx   = (funct7 == F7_ALT) ? INST_SRAI : INST_SRLI;
            dec_imm   = imm_sh;
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        dec_type    = TYPE_R;
        dec_wr      = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_legal   = (funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
        unique case (funct3)
          3'b000:  dec_idx = (funct7 == F7_ALT) ? INST_SUB : INST_ADD;
          3'b001:  dec_idx = INST_SLL;
          3'b010:  dec_idx = INST_SLT;
          3'b011:  dec_idx = INST_SLTU;
          3'b100:  dec_idx = INST_XOR;
          3'b101:  dec_idx = (funct7 == F7_ALT) ? INST_SRA : INST_SRL;
          3'b110:  dec_idx = INST_OR;
          default: dec_idx = INST_AND;
        endcase
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    // An illegal encoding reads nothing and writes nothing, so it can never stall or forward.
    if (!dec_legal) begin
      dec_idx     = INST_IDX_NOP;
      dec_type    = INST_TYPE_NOP;
      dec_wr      = 1'b0;
      dec_use_rs1 = 1'b0;
      dec_use_rs2 = 1'b0;
      dec_use_imm = 1'b0;
      dec_imm     = '0;
    end
  end

  logic [XLEN-1:0] op1_data;
  logic [XLEN-1:0] op2_data;

  id_operand_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel_rs1 (
    .used    (dec_use_rs1),
    .idx     (rs1),
    .rf_data (reg1Data_in),
    .fwd_e   (fwdE_in),
    .fwd_idx (fwdIdx_in),
    .fwd_data(fwdData_in),
    .data    (op1_data)
  );

  id_operand_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel_rs2 (
    .used    (dec_use_rs2),
    .idx     (rs2),
    .rf_data (reg2Data_in),
    .fwd_e   (fwdE_in),
    .fwd_idx (fwdIdx_in),
    .fwd_data(fwdData_in),
    .data    (op2_data)
  );

  logic [XLEN-1:0] dec_rs1_data;
  logic            hazard;
  logic            capture;
  logic            valid_reg;

  assign dec_rs1_data = (dec_idx == INST_AUIPC) ? pc_in : op1_data;

  assign hazard = inValid_in && ldE_in && (ldIdx_in != 5'd0) &&
                  ((dec_use_rs1 && ldIdx_in == rs1) || (dec_use_rs2 && ldIdx_in == rs2));

  // rst_in gates ready so nothing is accepted while the output slot is forced empty.
  assign inReady_out = rst_in && (!valid_reg || outReady_in) && !hazard && !flush_in;
  assign capture     = inValid_in && inReady_out;

  logic                   valid_next;
  logic [XLEN-1:0]        pc_reg, pc_next;
  inst_idx_e              idx_reg, idx_next;
  inst_type_e             type_reg, type_next;
  logic                   rd_e_reg, rd_e_next;
  logic [4:0]             rd_idx_reg, rd_idx_next;
  logic [XLEN-1:0]        rs1_reg, rs1_next;
  logic [XLEN-1:0]        rs2_reg, rs2_next;
  logic [XLEN-1:0]        imm_reg, imm_next;
  logic                   use_imm_reg, use_imm_next;
  logic                   illegal_reg, illegal_next;
  logic                   go_bubble;

  assign go_bubble = flush_in || (!capture && outReady_in);

  always_comb begin
    valid_next   = valid_reg;
    pc_next      = pc_reg;
    idx_next     = idx_reg;
    type_next    = type_reg;
    rd_e_next    = rd_e_reg;
    rd_idx_next  = rd_idx_reg;
    rs1_next     = rs1_reg;
    rs2_next     = rs2_reg;
    imm_next     = imm_reg;
    use_imm_next = use_imm_reg;
    illegal_next = illegal_reg;
    if (go_bubble) begin
      valid_next   = 1'b0;
      pc_next      = '0;
      idx_next     = INST_IDX_NOP;
      type_next    = INST_TYPE_NOP;
      rd_e_next    = 1'b0;
      rd_idx_next  = '0;
      rs1_next     = '0;
      rs2_next     = '0;
      imm_next     = '0;
      use_imm_next = 1'b0;
      illegal_next = 1'b0;
    end else if (capture) begin
      valid_next   = 1'b1;
      pc_next      = pc_in;
      idx_next     = dec_idx;
      type_next    = dec_type;
      rd_e_next    = dec_wr && (rd != 5'd0);
      rd_idx_next  = rd;
      rs1_next     = dec_rs1_data;
      rs2_next     = op2_data;
      imm_next     = dec_imm;
      use_imm_next = dec_use_imm;
      illegal_next = !dec_legal;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_reg   <= 1'b0;
      pc_reg      <= '0;
      idx_reg     <= INST_IDX_NOP;
      type_reg    <= INST_TYPE_NOP;
      rd_e_reg    <= 1'b0;
      rd_idx_reg  <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      imm_reg     <= '0;
      use_imm_reg <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      valid_reg   <= valid_next;
      pc_reg      <= pc_next;
      idx_reg     <= idx_next;
      type_reg    <= type_next;
      rd_e_reg    <= rd_e_next;
      rd_idx_reg  <= rd_idx_next;
      rs1_reg     <= rs1_next;
      rs2_reg     <= rs2_next;
      imm_reg     <= imm_next;
      use_imm_reg <= use_imm_next;
      illegal_reg <= illegal_next;
    end
  end

  assign outValid_out = valid_reg;
  assign pc_out       = pc_reg;
  assign instIdx_out  = idx_reg;
  assign instType_out = type_reg;
  assign rdE_out      = rd_e_reg;
  assign rdIdx_out    = rd_idx_reg;
  assign rs1Data_out  = rs1_reg;
  assign rs2Data_out  = rs2_reg;
  assign imm_out      = imm_reg;
  assign useImm_out   = use_imm_reg;
  assign illegal_out  = illegal_reg;

endmodule

// File: tb/tb_id_fwd_pipe.sv
// Bench for id_fwd_pipe: directed scenarios with literal expectations, then random
// traffic checked every cycle against an instruction-level reference model.
module tb_id_fwd_pipe;
  import id_fwd_pipe_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;

  logic                    clk_in;
  logic                    rst_in;
  logic                    inValid_in;
  logic                    inReady_out;
  logic [XLEN-1:0]         pc_in;
  logic [31:0]             inst_in;
  logic [4:0]              reg1Idx_out;
  logic [4:0]              reg2Idx_out;
  logic [XLEN-1:0]         reg1Data_in;
  logic [XLEN-1:0]         reg2Data_in;
  logic [NUM_FWD-1:0]      fwdE_in;
  logic [5*NUM_FWD-1:0]    fwdIdx_in;
  logic [XLEN*NUM_FWD-1:0] fwdData_in;
  logic                    ldE_in;
  logic [4:0]              ldIdx_in;
  logic                    flush_in;
  logic                    outValid_out;
  logic                    outReady_in;
  logic [XLEN-1:0]         pc_out;
  logic [INST_IDX_W-1:0]   instIdx_out;
  logic [INST_TYPE_W-1:0]  instType_out;
  logic                    rdE_out;
  logic [4:0]              rdIdx_out;
  logic [XLEN-1:0]         rs1Data_out;
  logic [XLEN-1:0]         rs2Data_out;
  logic [XLEN-1:0]         imm_out;
  logic                    useImm_out;
  logic                    illegal_out;

  id_fwd_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .inValid_in(inValid_in), .inReady_out(inReady_out),
    .pc_in(pc_in), .inst_in(inst_in),
    .reg1Idx_out(reg1Idx_out), .reg2Idx_out(reg2Idx_out),
    .reg1Data_in(reg1Data_in), .reg2Data_in(reg2Data_in),
    .fwdE_in(fwdE_in), .fwdIdx_in(fwdIdx_in), .fwdData_in(fwdData_in),
    .ldE_in(ldE_in), .ldIdx_in(ldIdx_in), .flush_in(flush_in),
    .outValid_out(outValid_out), .outReady_in(outReady_in),
    .pc_out(pc_out), .instIdx_out(instIdx_out), .instType_out(instType_out),
    .rdE_out(rdE_out), .rdIdx_out(rdIdx_out),
    .rs1Data_out(rs1Data_out), .rs2Data_out(rs2Data_out),
    .imm_out(imm_out), .useImm_out(useImm_out), .illegal_out(illegal_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [31:0] rf [32];
  logic        f_e   [NUM_FWD];
  logic [4:0]  f_idx [NUM_FWD];
  logic [31:0] f_dat [NUM_FWD];

  assign reg1Data_in = rf[reg1Idx_out];
  assign reg2Data_in = rf[reg2Idx_out];

  always_comb begin
    fwdE_in    = '0;
    fwdIdx_in  = '0;
    fwdData_in = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      fwdE_in[i]            = f_e[i];
      fwdIdx_in[5*i +: 5]   = f_idx[i];
      fwdData_in[32*i +: 32] = f_dat[i];
    end
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  idx;
    logic [1:0]  typ;
    logic        rd_e;
    logic [4:0]  rd_idx;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
    logic        u1;
    logic        u2;
  } exp_t;

  exp_t m;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic used);
    if (!used || idx == 5'd0) return 32'd0;
    for (int i = 0; i < NUM_FWD; i++)
      if (f_e[i] && f_idx[i] == idx) return f_dat[i];
    return rf[idx];
  endfunction

  // Instruction-level view: what the slot must hold if this instruction is accepted.
  function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic ok;
    opc = inst[6:0];
    f7  = inst[31:25];
    f3  = inst[14:12];
    e   = bubble();
    ok  = 1'b1;
    case (opc)
      7'h37: begin e.idx = INST_LUI;   e.typ = TYPE_U; e.imm = {inst[31:12], 12'h000}; e.use_imm = 1'b1; end
      7'h17: begin e.idx = INST_AUIPC; e.typ = TYPE_U; e.imm = {inst[31:12], 12'h000}; e.use_imm = 1'b1; end
      7'h13: begin
        e.typ = TYPE_I; e.u1 = 1'b1; e.use_imm = 1'b1;
        case (f3)
          3'd0: e.idx = INST_ADDI;
          3'd2: e.idx = INST_SLTI;
          3'd3: e.idx = INST_SLTIU;
          3'd4: e.idx = INST_XORI;
          3'd6: e.idx = INST_ORI;
          3'd7: e.idx = INST_ANDI;
          3'd1: begin e.idx = INST_SLLI; ok = (f7 == 7'h00); end
          default: begin
            e.idx = (f7 == 7'h20) ? INST_SRAI : INST_SRLI;
            ok    = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
      end
      7'h33: begin
        e.typ = TYPE_R; e.u1 = 1'b1; e.u2 = 1'b1;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0: e.idx = (f7 == 7'h20) ? INST_SUB : INST_ADD;
          3'd1: e.idx = INST_SLL;
          3'd2: e.idx = INST_SLT;
          3'd3: e.idx = INST_SLTU;
          3'd4: e.idx = INST_XOR;
          3'd5: e.idx = (f7 == 7'h20) ? INST_SRA : INST_SRL;
          3'd6: e.idx = INST_OR;
          default: e.idx = INST_AND;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = bubble();
      e.illegal = 1'b1;
    end
    e.rd_idx = inst[11:7];
    e.rd_e   = ok && inst[11:7] != 5'd0;
    e.rs1    = (ok && opc == 7'h17) ? pc : resolve(inst[19:15], e.u1);
    e.rs2    = resolve(inst[24:20], e.u2);
    e.pc     = pc;
    e.valid  = 1'b1;
    return e;
  endfunction

  task automatic compare_outputs();
    chk("out_valid", 32'(outValid_out), 32'(m.valid));
    chk("rd_e", 32'(rdE_out), 32'(m.rd_e));
    chk("inst_idx", 32'(instIdx_out), 32'(m.idx));
    if (m.valid) begin
      chk("pc", pc_out, m.pc);
      chk("illegal", 32'(illegal_out), 32'(m.illegal));
      chk("inst_type", 32'(instType_out), 32'(m.typ));
      if (!m.illegal) begin
        chk("rd_idx", 32'(rdIdx_out), 32'(m.rd_idx));
        chk("use_imm", 32'(useImm_out), 32'(m.use_imm));
        chk("rs1_data", rs1Data_out, m.rs1);
        chk("rs2_data", rs2Data_out, m.rs2);
        if (m.use_imm) chk("imm", imm_out, m.imm);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    exp_t d;
    logic hz, rdy, cap;
    #1;
    d   = model_decode(inst_in, pc_in);
    hz  = inValid_in && ldE_in && ldIdx_in != 5'd0 &&
          ((d.u1 && ldIdx_in == inst_in[19:15]) || (d.u2 && ldIdx_in == inst_in[24:20]));
    rdy = rst_in && (!m.valid || outReady_in) && !hz && !flush_in;
    cap = inValid_in && rdy;
    chk("in_ready", 32'(inReady_out), 32'(rdy));
    chk("reg1_idx", 32'(reg1Idx_out), 32'(inst_in[19:15]));
    chk("reg2_idx", 32'(reg2Idx_out), 32'(inst_in[24:20]));
    @(posedge clk_in);
    if (flush_in) m = bubble();
    else if (cap) begin
      m = d;
      n_txn++;
      $display("txn %0d: pc=%h inst=%h idx=%0d rs1=%h rs2=%h", n_txn, d.pc, inst_in, d.idx, d.rs1, d.rs2);
    end else if (outReady_in) m = bubble();
    #1;
    compare_outputs();
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] hi;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          sel;
    hi  = $urandom;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       f7 = 7'h20;
      1:       f7 = hi[31:25];
      default: f7 = 7'h00;
    endcase
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       return {hi[31:12], rd, OPC_LUI};
      1:       return {hi[31:12], rd, OPC_AUIPC};
      2, 3, 4: return {f7, rs2, rs1, f3, rd, OPC_OP_IMM};
      5, 6, 7: return {f7, rs2, rs1, f3, rd, OPC_OP};
      8:       return hi;
      default: return 32'h0000000B;
    endcase
  endfunction

  task automatic fwd_off();
    for (int i = 0; i < NUM_FWD; i++) begin
      f_e[i] = 1'b0; f_idx[i] = 5'd0; f_dat[i] = 32'd0;
    end
  endtask

  initial begin
    rst_in = 1'b0; inValid_in = 1'b0; pc_in = '0; inst_in = 32'h0000_0013;
    ldE_in = 1'b0; ldIdx_in = '0; flush_in = 1'b0; outReady_in = 1'b1;
    fwd_off();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;  // x0 must read as zero no matter what the regfile returns
    m = bubble();

    // Reset state, with a valid instruction offered that must not be accepted
    repeat (2) @(negedge clk_in);
    inValid_in = 1'b1; inst_in = 32'hFFF00293;
    #1;
    chk("rst_in_ready", 32'(inReady_out), 32'd0);
    chk("rst_out_valid", 32'(outValid_out), 32'd0);
    chk("rst_inst_idx", 32'(instIdx_out), 32'(INST_NOP));
    inValid_in = 1'b0;
    rst_in = 1'b1;
    @(negedge clk_in);

    // ADDI x5,x0,-1
    inValid_in = 1'b1; inst_in = 32'hFFF00293; pc_in = 32'h0000_0100;
    step();
    chk("addi_valid", 32'(outValid_out), 32'd1);
    chk("addi_imm", imm_out, 32'hFFFF_FFFF);
    chk("addi_rs1", rs1Data_out, 32'd0);
    chk("addi_rd_idx", 32'(rdIdx_out), 32'd5);
    chk("addi_use_imm", 32'(useImm_out), 32'd1);
    inValid_in = 1'b0;
    step();
    chk("bubble_valid", 32'(outValid_out), 32'd0);

    // ADD x3,x1,x2 with both sources forwarding x1: source 0 wins
    rf[2] = 32'd7;
    f_e[0] = 1'b1; f_idx[0] = 5'd1; f_dat[0] = 32'hA;
    f_e[1] = 1'b1; f_idx[1] = 5'd1; f_dat[1] = 32'hB;
    inValid_in = 1'b1; inst_in = 32'h002081B3; pc_in = 32'h0000_0104;
    step();
    chk("add_rs1_fwd", rs1Data_out, 32'hA);
    chk("add_rs2_rf", rs2Data_out, 32'd7);
    fwd_off();

    // SUB x4,x1,x2 behind a load into x1
    ldE_in = 1'b1; ldIdx_in = 5'd1; inst_in = 32'h40208233; pc_in = 32'h0000_0108;
    #1;
    chk("hazard_ready", 32'(inReady_out), 32'd0);
    step();
    chk("hazard_bubble", 32'(outValid_out), 32'd0);
    ldE_in = 1'b0;
    step();
    chk("hazard_release", 32'(outValid_out), 32'd1);
    chk("hazard_sub_idx", 32'(instIdx_out), 32'(INST_SUB));

    // Downstream stall for three cycles with a new instruction waiting
    outReady_in = 1'b0; inst_in = 32'hFFF00293; pc_in = 32'h0000_010C;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready", 32'(inReady_out), 32'd0);
      step();
      chk("hold_idx", 32'(instIdx_out), 32'(INST_SUB));
      chk("hold_pc", pc_out, 32'h0000_0108);
    end
    outReady_in = 1'b1;
    step();
    chk("hold_release_idx", 32'(instIdx_out), 32'(INST_ADDI));
    chk("hold_release_pc", pc_out, 32'h0000_010C);

    // Flush while the slot is held and a new instruction is offered
    outReady_in = 1'b0; flush_in = 1'b1; inst_in = 32'h002081B3; pc_in = 32'h0000_0110;
    step();
    chk("flush_valid", 32'(outValid_out), 32'd0);
    flush_in = 1'b0; outReady_in = 1'b1;

    // Custom opcode, then reset in the middle of a hold
    inst_in = 32'h0000000B; pc_in = 32'h0000_0114;
    step();
    chk("ill_flag", 32'(illegal_out), 32'd1);
    chk("ill_rd_e", 32'(rdE_out), 32'd0);
    chk("ill_idx", 32'(instIdx_out), 32'(INST_NOP));
    outReady_in = 1'b0; inValid_in = 1'b0;
    step();
    #2 rst_in = 1'b0;
    #1;
    chk("arst_valid", 32'(outValid_out), 32'd0);
    chk("arst_illegal", 32'(illegal_out), 32'd0);
    chk("arst_pc", pc_out, 32'd0);
    chk("arst_rs1", rs1Data_out, 32'd0);
    chk("arst_type", 32'(instType_out), 32'(TYPE_NOP));
    chk("arst_ready", 32'(inReady_out), 32'd0);
    m = bubble();
    @(negedge clk_in);
    rst_in = 1'b1; outReady_in = 1'b1;
    step();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      int r;
      inValid_in  = ($urandom_range(0, 3) != 0);
      inst_in     = rand_inst();
      pc_in       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      outReady_in = ($urandom_range(0, 9) < 7);
      flush_in    = ($urandom_range(0, 9) == 0);
      ldE_in      = ($urandom_range(0, 3) == 0);
      ldIdx_in    = 5'($urandom_range(0, 7));
      for (int i = 0; i < NUM_FWD; i++) begin
        f_e[i]   = ($urandom_range(0, 1) == 1);
        f_idx[i] = 5'($urandom_range(0, 7));
        f_dat[i] = $urandom;
      end
      if (c % 40 == 0) begin
        r = int'($urandom_range(0, 7));
        rf[r] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_fwd_pipe.md
ID_FWD_PIPE -- requirements
Module: id_fwd_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources; source 0 = youngest, highest priority.
REQ-003 SHALL have ports clk_in input 1, single clock; rst_in input 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports inValid_in input 1, upstream instruction valid; inReady_out output 1, decoder accepts this cycle.
REQ-005 SHALL have ports pc_in input XLEN, instruction PC; inst_in input 32, instruction word.
REQ-006 SHALL have ports reg1Idx_out, reg2Idx_out output 5, regfile read indices, combinational from inst_in.
REQ-007 SHALL have ports reg1Data_in, reg2Data_in input XLEN, regfile read data, same cycle.
REQ-008 SHALL have ports fwdE_in input NUM_FWD, fwdIdx_in input 5*NUM_FWD, fwdData_in input XLEN*NUM_FWD, packed forwarding sources.
REQ-009 SHALL have ports ldE_in input 1, ldIdx_in input 5, load in EX and its destination.
REQ-010 SHALL have port flush_in input 1, discard held and incoming instruction.
REQ-011 SHALL have ports outValid_out output 1, outReady_in input 1, downstream handshake.
REQ-012 SHALL have registered outputs pc_out XLEN, instIdx_out, instType_out (package widths), rdE_out 1, rdIdx_out 5, rs1Data_out XLEN, rs2Data_out XLEN, imm_out XLEN, useImm_out 1, illegal_out 1.

Function
REQ-013 SHALL decode LUI, AUIPC, OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
REQ-014 SHALL produce imm: I-type sign-extended inst[31:20]; shifts zero-extended inst[24:20]; U-type {inst[31:12],12'b0}.
REQ-015 SHALL set illegal_out=1, rdE_out=0, instIdx_out=NOP for unsupported opcode, funct3, or funct7 (incl. SLLI/SRLI with funct7!=0, SRAI with funct7!=0100000).
REQ-016 SHALL force rdE_out=0 when rd==x0.
REQ-017 SHALL assert useImm_out for OP-IMM/LUI/AUIPC; rs2Data_out then 0; LUI rs1Data_out=0, AUIPC rs1Data_out=pc_in.
REQ-018 SHALL resolve each source operand: x0 -> 0; else lowest-index matching enabled fwd source; else regfile data.
REQ-019 SHALL never forward to an operand not read by the instruction.
REQ-020 SHALL detect load-use hazard: inValid_in & ldE_in & ldIdx_in!=0 & ldIdx_in equals a read source index.
REQ-021 SHALL drive inReady_out = (!outValid_out | outReady_in) & !hazard & !flush_in.
REQ-022 SHALL capture decode results at clock edge when inValid_in & inReady_out; latency 1 cycle.
REQ-023 SHALL clear outValid_out (bubble) at edge when outReady_in=1 and no capture occurs.
REQ-024 SHALL hold all outputs stable while outValid_out & !outReady_in.
REQ-025 SHALL clear outValid_out at edge when flush_in=1, overriding capture and hold.
REQ-026 SHALL not enter bubble outputs with rdE_out=1: bubbles force rdE_out=0, instIdx_out=NOP.

Reset
REQ-027 SHALL, while rst_in=0, asynchronously set outValid_out=0, rdE_out=0, illegal_out=0, useImm_out=0, instIdx_out=NOP, instType_out=NOP, rdIdx_out=0, all data outputs 0.
REQ-028 SHALL hold inReady_out=0 during reset; first capture on first edge after rst_in rises.

Structure
REQ-029 SHALL place opcodes, instIdx/instType encodings and widths, NOP values in the shared defines package.
REQ-030 SHALL implement operand resolution as sub-module id_operand_sel (parametrised XLEN, NUM_FWD), instantiated twice.
REQ-031 SHALL keep decode combinational and one output register stage; no other state.

Verification
REQ-032 ADDI x5,x0,-1 (0xFFF00293) -> next cycle outValid=1, imm_out=0xFFFFFFFF, rs1Data_out=0, rdIdx_out=5, useImm_out=1.
REQ-033 ADD x3,x1,x2, fwd0 {x1,0xA}, fwd1 {x1,0xB}, regfile x2=7 -> rs1Data_out=0xA, rs2Data_out=7.
REQ-034 ldE_in=1, ldIdx_in=1, SUB x4,x1,x2 -> inReady_out=0, next cycle outValid_out=0; drop ldE_in -> captured next edge.
REQ-035 outValid=1, outReady_in=0 three cycles with new input -> outputs unchanged, inReady_out=0; outReady_in=1 -> new instruction next edge.
REQ-036 flush_in=1 with valid held and inValid_in=1 -> next cycle outValid_out=0, no capture.
REQ-037 0x0000000B (custom opcode), then rst_in low mid-hold -> illegal_out=1, rdE_out=0; reset clears all outputs immediately.
